seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 23 ++
 rtl/hack_alu_core.sv | 23 ++
 rtl/seq_alu.sv | 152 +++++++++++++++
 tb/tb_seq_alu.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation modes, FSM states and
// bit positions inside the Hack-style control word.
package alu_pkg;

  localparam logic [1:0] MODE_HACK = 2'b00;
  localparam logic [1:0] MODE_MUL  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_SRA  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // ctrl = {zx, nx, zy, ny, f, no}
  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

endpackage

// File: rtl/hack_alu_core.sv
// Combinational Hack-style ALU: optional zero/invert on each operand,
// add or AND, optional output invert.
module hack_alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [5:0]       ctrl_i,
  output logic [WIDTH-1:0] res_o
);

  logic [WIDTH-1:0] x_z, x_n, y_z, y_n, f_out;

  assign x_z   = ctrl_i[CTRL_ZX] ? '0 : x_i;
  assign x_n   = ctrl_i[CTRL_NX] ? ~x_z : x_z;
  assign y_z   = ctrl_i[CTRL_ZY] ? '0 : y_i;
  assign y_n   = ctrl_i[CTRL_NY] ? ~y_z : y_z;
  assign f_out = ctrl_i[CTRL_F] ? (x_n + y_n) : (x_n & y_n);
  assign res_o = ctrl_i[CTRL_NO] ? ~f_out : f_out;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes: single-cycle Hack/shift
// operations and an optional WIDTH-cycle signed shift-add multiplier.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zr,
  output logic             ng,
  output logic             ovf
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zr_q, ng_q, ovf_q, ovf_d;
  logic [WIDTH-1:0]   hack_res;
  logic [SHAMT_W-1:0] shamt;
  logic               mul_load, mul_step, mul_last, mul_ovf;
  logic [2*WIDTH-1:0] mul_prod;

  hack_alu_core #(.WIDTH(WIDTH)) u_core (
    .x_i   (x),
    .y_i   (y),
    .ctrl_i(ctrl),
    .res_o (hack_res)
  );

  assign shamt = y[SHAMT_W-1:0];

  if (MUL_EN != 0) begin : g_mul
    logic [WIDTH-1:0]   x_q, y_q;
    logic [2*WIDTH-1:0] acc_q, acc_d, pp;
    logic [CNT_W-1:0]   cnt_q;

    // The multiplier MSB carries negative weight, so the last partial
    // product is subtracted rather than added.
    always_comb begin
      pp    = y_q[cnt_q] ? ({{WIDTH{x_q[WIDTH-1]}}, x_q} << cnt_q) : '0;
      acc_d = mul_last ? (acc_q - pp) : (acc_q + pp);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        x_q   <= '0;
        y_q   <= '0;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (mul_load) begin
        x_q   <= x;
        y_q   <= y;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (mul_step) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));
    assign mul_prod = acc_d;
  end else begin : g_no_mul
    assign mul_last = 1'b1;
    assign mul_prod = '0;
  end

  assign mul_ovf = (mul_prod[2*WIDTH-1:WIDTH] != {WIDTH{mul_prod[WIDTH-1]}});

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_DONE;
          ovf_d   = 1'b0;
          unique case (mode)
            MODE_HACK: result_d = hack_res;
            MODE_SHL:  result_d = x << shamt;
            MODE_SRA:  result_d = $signed(x) >>> shamt;
            MODE_MUL: begin
              if (MUL_EN != 0) begin
                mul_load = 1'b1;
                state_d  = ST_CALC;
              end else begin
                result_d = '0;
                ovf_d    = 1'b1;
              end
            end
          endcase
        end
      end
      ST_CALC: begin
        mul_step = 1'b1;
        if (mul_last) begin
          result_d = mul_prod[WIDTH-1:0];
          ovf_d    = mul_ovf;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zr_q     <= 1'b1;
      ng_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zr_q     <= (result_d == '0);
      ng_q     <= result_d[WIDTH-1];
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=16 with the multiplier built.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic [5:0]  ctrl = '0;
  logic [1:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        zr, ng, ovf;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] ax;
    logic [15:0] ay;
    logic [5:0]  actrl;
    logic [1:0]  amode;
    logic [15:0] res;
    logic        ezr;
    logic        eng;
    logic        eovf;
    int          lat;
  } vec_t;

  seq_alu #(.WIDTH(16), .MUL_EN(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .ctrl     (ctrl),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zr       (zr),
    .ng       (ng),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [15:0] ax, input logic [15:0] ay,
                       input logic [5:0] actrl, input logic [1:0] amode);
    @(negedge clk);
    x = ax; y = ay; ctrl = actrl; mode = amode; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency 1 means out_valid is already up just after the acceptance edge.
  task automatic wait_done(input bit noise, output int lat);
    lat = 1;
    if (noise) begin
      in_valid = 1'b1; x = 16'h1234; y = 16'h0001; ctrl = 6'b000010; mode = MODE_HACK;
    end
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input string tag, input int idx, input vec_t v, input bit noise);
    int lat;
    issue(v.ax, v.ay, v.actrl, v.amode);
    wait_done(noise, lat);
    n_vec++;
    if (lat !== v.lat) begin
      n_err++; $display("FAIL %s[%0d] latency: got %0d expected %0d", tag, idx, lat, v.lat);
    end
    n_vec++;
    if (result !== v.res) begin
      n_err++; $display("FAIL %s[%0d] result: got %h expected %h", tag, idx, result, v.res);
    end
    n_vec++;
    if ({zr, ng, ovf} !== {v.ezr, v.eng, v.eovf}) begin
      n_err++; $display("FAIL %s[%0d] zr/ng/ovf: got %b%b%b expected %b%b%b",
                        tag, idx, zr, ng, ovf, v.ezr, v.eng, v.eovf);
    end
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL %s[%0d] return to idle: got rdy=%b vld=%b expected rdy=1 vld=0",
                        tag, idx, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_vec++;
    if ({in_ready, out_valid, zr, ng, ovf} !== 5'b10100 || result !== 16'h0000) begin
      n_err++; $display("FAIL reset: got rdy=%b vld=%b res=%h zr=%b ng=%b ovf=%b expected 1 0 0000 1 0 0",
                        in_ready, out_valid, result, zr, ng, ovf);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_hack();
    vec_t t[6];
    t[0] = '{16'h3095, 16'h2795, 6'b010101, MODE_HACK, 16'h3795, 1'b0, 1'b0, 1'b0, 1};
    t[1] = '{16'h3095, 16'h2795, 6'b000010, MODE_HACK, 16'h582A, 1'b0, 1'b0, 1'b0, 1};
    t[2] = '{16'h3095, 16'h2795, 6'b101010, MODE_HACK, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    t[3] = '{16'h3095, 16'h2795, 6'b000000, MODE_HACK, 16'h2095, 1'b0, 1'b0, 1'b0, 1};
    t[4] = '{16'h3095, 16'h2795, 6'b001101, MODE_HACK, 16'hCF6A, 1'b0, 1'b1, 1'b0, 1};
    t[5] = '{16'h3095, 16'h2795, 6'b111111, MODE_HACK, 16'h0001, 1'b0, 1'b0, 1'b0, 1};
    for (int i = 0; i < 6; i++) run_vec("hack", i, t[i], 1'b0);
  endtask

  task automatic test_shift();
    vec_t t[4];
    t[0] = '{16'h8000, 16'h0003, 6'b000000, MODE_SRA, 16'hF000, 1'b0, 1'b1, 1'b0, 1};
    t[1] = '{16'h0001, 16'h000F, 6'b000000, MODE_SHL, 16'h8000, 1'b0, 1'b1, 1'b0, 1};
    t[2] = '{16'h7FF0, 16'h0004, 6'b000000, MODE_SRA, 16'h07FF, 1'b0, 1'b0, 1'b0, 1};
    t[3] = '{16'h00FF, 16'h0014, 6'b000000, MODE_SHL, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1};
    for (int i = 0; i < 4; i++) run_vec("shift", i, t[i], 1'b0);
  endtask

  // in_valid is held high throughout CALC; it must not disturb the product.
  task automatic test_mul();
    vec_t t[4];
    t[0] = '{16'hFFFD, 16'h0007, 6'b000000, MODE_MUL, 16'hFFEB, 1'b0, 1'b1, 1'b0, 17};
    t[1] = '{16'h0100, 16'h0100, 6'b000000, MODE_MUL, 16'h0000, 1'b1, 1'b0, 1'b1, 17};
    t[2] = '{16'h8000, 16'hFFFF, 6'b000000, MODE_MUL, 16'h8000, 1'b0, 1'b1, 1'b1, 17};
    t[3] = '{16'h0005, 16'hFFFA, 6'b000000, MODE_MUL, 16'hFFE2, 1'b0, 1'b1, 1'b0, 17};
    for (int i = 0; i < 4; i++) run_vec("mul", i, t[i], 1'b1);
  endtask

  task automatic test_hold();
    int lat;
    out_ready = 1'b0;
    issue(16'h3095, 16'h2795, 6'b010101, MODE_HACK);
    wait_done(1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; x = 16'($urandom); y = 16'($urandom);
      ctrl = 6'($urandom); mode = 2'($urandom);
      @(posedge clk); #1;
      n_vec++;
      if (result !== 16'h3795 || {out_valid, in_ready, zr, ng, ovf} !== 5'b10000) begin
        n_err++; $display("FAIL hold[%0d]: got res=%h vld=%b rdy=%b zr=%b ng=%b ovf=%b expected 3795 1 0 0 0 0",
                          i, result, out_valid, in_ready, zr, ng, ovf);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL hold release: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    vec_t v;
    issue(16'hFFFD, 16'h0007, 6'b000000, MODE_MUL);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 || zr !== 1'b1) begin
      n_err++; $display("FAIL mid-mul reset: got rdy=%b vld=%b res=%h zr=%b expected 1 0 0000 1",
                        in_ready, out_valid, result, zr);
    end
    @(negedge clk); rst = 1'b0;
    v = '{16'h3095, 16'h2795, 6'b000010, MODE_HACK, 16'h582A, 1'b0, 1'b0, 1'b0, 1};
    run_vec("post-reset", 0, v, 1'b0);
  endtask

  // With in_valid held high, a handshake edge must not also accept.
  task automatic test_back_to_back();
    @(negedge clk);
    x = 16'h0003; y = 16'h0004; ctrl = 6'b000010; mode = MODE_HACK; in_valid = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b1 || result !== 16'h0007) begin
      n_err++; $display("FAIL b2b first: got vld=%b res=%h expected 1 0007", out_valid, result);
    end
    x = 16'h0010;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b gap: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || result !== 16'h0014) begin
      n_err++; $display("FAIL b2b second: got vld=%b res=%h expected 1 0014", out_valid, result);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_hack();
    test_shift();
    test_mul();
    test_hold();
    test_reset_mid_mul();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
